mem_sram_ctrl: RTL

- MEM-stage memory controller. It accepts the same read/write/address/data request the on-chip data memory accepts, and serves it from an external 16-bit asynchronous SRAM.
- Each 32-bit access is split into two 16-bit SRAM accesses: low half first, then high half. Each half lasts a programmable number of wait cycles.
- The `ready` output drives the pipeline freeze. While `ready`=0 the upstream stages hold their request stable.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/sram_phase_counter.sv | 41 ++++
 rtl/mem_sram_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: constants shared by the SRAM controller and its phase counter.
//   - FSM state encoding (IDLE, LO, HI, DONE)
//   - default SRAM base byte address, SRAM data width, phase counter width
//   - word_index(): byte address to 32-bit word index relative to a base
package mem_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LO   = 2'd1;
   localparam logic [1:0] HI   = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;
   localparam int          SRAM_DW       = 16;
   localparam int          CNT_W         = 4;

   // Unsigned 32-bit wrap is intentional: addresses below the base alias
   // high in the index space and are then truncated by the caller.
   function automatic logic [31:0] word_index(input logic [31:0] addr,
                                              input logic [31:0] base);
      return (addr - base) >> 2;
   endfunction

endpackage

// File: rtl/sram_phase_counter.sv
// sram_phase_counter: wait counter shared by the LO and HI half-word phases.
// Ports:
//   clk     - clock
//   rst     - synchronous reset, active-low
//   clr     - load zero on the next edge instead of incrementing
//   tc      - current count equals WAIT_CYCLES-1 (last cycle of a phase)
//   tc_nxt  - count after the next edge will equal WAIT_CYCLES-1; lets the
//             controller register sram_we_n so it rises on the last cycle
module sram_phase_counter
   import mem_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tc,
   output logic tc_nxt
);

   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(WAIT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = clr ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc     = (cnt_q == TC_VAL);
   assign tc_nxt = (cnt_d == TC_VAL);

endmodule

// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: MEM-stage data memory front end that serves 32-bit accesses
// from a 16-bit asynchronous SRAM, low half first then high half, each half
// held for WAIT_CYCLES cycles. ready=0 freezes the pipeline.
//
// Ports:
//   clk, rst              - clock, synchronous active-low reset
//   mem_read, mem_write   - request from MEM stage (both set = write)
//   address, data         - byte address and write data
//   res                   - read result, valid in the ready=1 DONE cycle
//   ready                 - 0 = freeze pipeline
//   sram_addr             - halfword address {word index, half}
//   sram_dq_out/_oe       - write data and bus drive enable
//   sram_dq_in            - read data from SRAM
//   sram_we_n             - active-low write strobe
//
// Build option: define SRAM_RD_BUFFER_EN to add a one-entry read buffer that
// answers a repeated read of the same word without touching the SRAM.
//
// state | meaning
// IDLE  | waiting for a request; latches op, word index and write data
// LO    | low halfword access, WAIT_CYCLES cycles
// HI    | high halfword access, WAIT_CYCLES cycles
// DONE  | one-cycle completion, ready=1, res valid for reads
module mem_sram_ctrl
   import mem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned SRAM_AW     = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_read,
   input  logic               mem_write,
   input  logic [31:0]        address,
   input  logic [31:0]        data,
   output logic [31:0]        res,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [SRAM_DW-1:0] sram_dq_out,
   output logic               sram_dq_oe,
   input  logic [SRAM_DW-1:0] sram_dq_in,
   output logic               sram_we_n
);

   localparam int unsigned IW = SRAM_AW - 1;

   logic              req;
   logic [31:0]       widx_full;
   logic [IW-1:0]     widx_in;
   logic              unused_widx_hi;

   logic [1:0]        state_q,     state_d;
   logic              op_wr_q,     op_wr_d;
   logic [IW-1:0]     widx_q,      widx_d;
   logic [31:0]       wdata_q,     wdata_d;
   logic [31:0]       rdata_q,     rdata_d;
   logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
   logic [SRAM_DW-1:0] dq_out_q,   dq_out_d;
   logic              dq_oe_q,     dq_oe_d;
   logic              we_n_q,      we_n_d;

   logic              in_phase;
   logic              nxt_phase;
   logic              cnt_clr;
   logic              tc;
   logic              tc_nxt;

`ifdef SRAM_RD_BUFFER_EN
   logic              buf_valid_q, buf_valid_d;
   logic [IW-1:0]     buf_widx_q,  buf_widx_d;
   logic [31:0]       buf_word_q,  buf_word_d;
   logic              buf_match;
`endif

   assign req            = mem_read | mem_write;
   assign widx_full      = word_index(address, BASE_ADDR);
   assign widx_in        = widx_full[IW-1:0];
   assign unused_widx_hi = ^widx_full[31:IW];

   assign in_phase = (state_q == LO) || (state_q == HI);
   // Counter restarts whenever a phase is entered or left.
   assign cnt_clr  = ~in_phase | tc;

   sram_phase_counter #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_phase_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (cnt_clr),
      .tc     (tc),
      .tc_nxt (tc_nxt)
   );

`ifdef SRAM_RD_BUFFER_EN
   assign buf_match = buf_valid_q && (buf_widx_q == widx_in);
`endif

   always_comb begin
      state_d = state_q;
      op_wr_d = op_wr_q;
      widx_d  = widx_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
`ifdef SRAM_RD_BUFFER_EN
      buf_valid_d = buf_valid_q;
      buf_widx_d  = buf_widx_q;
      buf_word_d  = buf_word_q;
`endif
      case (state_q)
         IDLE: begin
            if (req) begin
               op_wr_d = mem_write;
               widx_d  = widx_in;
               wdata_d = data;
               state_d = LO;
`ifdef SRAM_RD_BUFFER_EN
               if (!mem_write && buf_match) begin
                  state_d = DONE;
                  rdata_d = buf_word_q;
               end
               if (mem_write && buf_match) begin
                  buf_valid_d = 1'b0;
               end
`endif
            end
         end
         LO: begin
            if (tc) begin
               state_d = HI;
               if (!op_wr_q) rdata_d[15:0] = sram_dq_in;
            end
         end
         HI: begin
            if (tc) begin
               state_d = DONE;
               if (!op_wr_q) begin
                  rdata_d[31:16] = sram_dq_in;
`ifdef SRAM_RD_BUFFER_EN
                  buf_valid_d = 1'b1;
                  buf_widx_d  = widx_q;
                  buf_word_d  = {sram_dq_in, rdata_q[15:0]};
`endif
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // SRAM pins are registered from next-state values so they are stable for
   // the whole phase; address and data hold outside phases (including a
   // buffer hit) so the bus stays quiet.
   assign nxt_phase = (state_d == LO) || (state_d == HI);

   always_comb begin
      sram_addr_d = sram_addr_q;
      dq_out_d    = dq_out_q;
      if (nxt_phase) begin
         sram_addr_d = {widx_d, state_d == HI};
         dq_out_d    = (state_d == HI) ? wdata_d[31:16] : wdata_d[15:0];
      end
      dq_oe_d = nxt_phase & op_wr_d;
      // Strobe low for all but the last cycle so address/data hold past
      // the rising edge of we_n.
      we_n_d  = ~(nxt_phase & op_wr_d & ~tc_nxt);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         op_wr_q     <= 1'b0;
         widx_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         sram_addr_q <= '0;
         dq_out_q    <= '0;
         dq_oe_q     <= 1'b0;
         we_n_q      <= 1'b1;
`ifdef SRAM_RD_BUFFER_EN
         buf_valid_q <= 1'b0;
         buf_widx_q  <= '0;
         buf_word_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         op_wr_q     <= op_wr_d;
         widx_q      <= widx_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         sram_addr_q <= sram_addr_d;
         dq_out_q    <= dq_out_d;
         dq_oe_q     <= dq_oe_d;
         we_n_q      <= we_n_d;
`ifdef SRAM_RD_BUFFER_EN
         buf_valid_q <= buf_valid_d;
         buf_widx_q  <= buf_widx_d;
         buf_word_q  <= buf_word_d;
`endif
      end
   end

   assign ready       = ~req | (state_q == DONE);
   assign res         = ((state_q == DONE) && !op_wr_q) ? rdata_q : 32'd0;
   assign sram_addr   = sram_addr_q;
   assign sram_dq_out = dq_out_q;
   assign sram_dq_oe  = dq_oe_q;
   assign sram_we_n   = we_n_q;

endmodule
